// File: rtl/game_pkg.sv
// Shared game-state encoding and key constants for the flow controller, score block and renderer.
package game_pkg;

  typedef enum logic [2:0] {
    GS_TITLE    = 3'd0,
    GS_PLAY     = 3'd1,
    GS_PAUSE    = 3'd2,
    GS_BLUE_WIN = 3'd3,
    GS_RED_WIN  = 3'd4
  } game_state_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame strobe edge detector plus a clearable frame counter with terminal-count detect.
module frame_timer #(
  parameter int unsigned CW = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          frame_clk_i,
  input  logic          clear_i,
  input  logic [CW-1:0] term_i,
  output logic          frame_tick_o,
  output logic          done_o
);

  logic          frame_clk_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign frame_tick_o = frame_clk_i & ~frame_clk_q;
  assign done_o       = frame_tick_o && (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (frame_tick_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_clk_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      frame_clk_q <= frame_clk_i;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow FSM: title, play, post-crash pause and win screens with frame timeouts.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned PAUSE_FRAMES = 90,
  parameter int unsigned WIN_FRAMES   = 300,
  parameter logic [7:0]  START_KEY    = KEY_ENTER
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       Blue_W,
  input  logic       Red_W,
  input  logic       reset_round,
  output logic [2:0] Game_State,
  output logic       Reset_Score,
  output logic       Reset_Bikes,
  output logic [3:0] round_num
);

  localparam int unsigned MaxFrames = max_u(PAUSE_FRAMES, WIN_FRAMES);
  localparam int unsigned CntW      = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

  game_state_t     state_q, state_d;
  logic [7:0]      key_q;
  logic [3:0]      round_q, round_d;
  logic            start_press;
  logic            frame_tick;
  logic            timer_done;
  logic            timer_clear;
  logic [CntW-1:0] timer_term;

  assign start_press = (keycode == START_KEY) && (key_q != START_KEY);
  assign timer_term  = (state_q == GS_PAUSE) ? CntW'(PAUSE_FRAMES - 1) : CntW'(WIN_FRAMES - 1);
  // Counter only runs in timed states and restarts from zero on every state change.
  assign timer_clear = (state_d != state_q) ||
                       !((state_q == GS_PAUSE) || (state_q == GS_BLUE_WIN) ||
                         (state_q == GS_RED_WIN));

  frame_timer #(
    .CW (CntW)
  ) u_frame_timer (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .frame_clk_i  (frame_clk),
    .clear_i      (timer_clear),
    .term_i       (timer_term),
    .frame_tick_o (frame_tick),
    .done_o       (timer_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= GS_TITLE;
      key_q   <= 8'h00;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= keycode;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GS_TITLE: if (start_press) state_d = GS_PLAY;
      GS_PLAY: begin
        if (Blue_W)           state_d = GS_BLUE_WIN;
        else if (Red_W)       state_d = GS_RED_WIN;
        else if (reset_round) state_d = GS_PAUSE;
      end
      GS_PAUSE: begin
        if (Blue_W)          state_d = GS_BLUE_WIN;
        else if (Red_W)      state_d = GS_RED_WIN;
        else if (timer_done) state_d = GS_PLAY;
      end
      GS_BLUE_WIN, GS_RED_WIN: begin
        if (start_press || timer_done) state_d = GS_TITLE;
      end
      default: state_d = GS_TITLE;
    endcase
  end

  always_comb begin
    round_d = round_q;
    if (state_d == GS_TITLE) begin
      round_d = 4'd0;
    end else if ((state_q == GS_PLAY) && (state_d == GS_PAUSE) && (round_q != 4'd15)) begin
      round_d = round_q + 4'd1;
    end
  end

  always_comb begin
    Game_State  = 3'd0;
    Reset_Score = 1'b1;
    Reset_Bikes = 1'b1;
    case (state_q)
      GS_PLAY: begin
        Game_State  = GS_PLAY;
        Reset_Score = 1'b0;
        Reset_Bikes = 1'b0;
      end
      GS_PAUSE, GS_BLUE_WIN, GS_RED_WIN: begin
        Game_State  = state_q;
        Reset_Score = 1'b0;
      end
      default: ;
    endcase
  end

  assign round_num = round_q;

endmodule
